// File: rtl/jtag_dtm.sv
// RISC-V JTAG Debug Transport Module: oversampled TAP with IDCODE/DTMCS/DMI/BYPASS, DMI initiator.
// Optional DMI watchdog enabled by defining DTM_TIMEOUT_EN.
module jtag_dtm #(
    parameter int          ABITS          = 7,
    parameter logic [31:0] IDCODE         = 32'h1000_0001,
    parameter int          SYNC_STAGES    = 2,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tck,
    input  logic             tms,
    input  logic             tdi,
    output logic             tdo,
    output logic             tdo_en,
    output logic             dmi_start,
    output logic [1:0]       dmi_op,
    output logic [ABITS-1:0] dmi_address,
    output logic [31:0]      dmi_wdata,
    input  logic [31:0]      dmi_rdata,
    input  logic             dmi_finish
);

    localparam int DMI_W = ABITS + 34;

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
        SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
    } tap_state_t;

    typedef enum logic [1:0] {D_IDLE, D_REQ, D_WAIT} dmi_state_t;

    logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync;
    logic                   tck_q;
    logic                   tck_s, tms_s, tdi_s, tck_rise, tck_fall;
    tap_state_t             tap_state, tap_next;
    dmi_state_t             dmi_state, dmi_next;
    logic [4:0]             ir, ir_shift;
    logic [DMI_W-1:0]       dr_shift, dr_capture, dr_shifted;
    logic [1:0]             dmistat;
    logic [31:0]            rdata_buf;
    logic                   sel_idcode, sel_dtmcs, sel_dmi, dmi_busy;
    logic                   upd_dtmcs, upd_dmi, cap_dmi;
    logic                   hard_reset, stat_clear, busy_hit, dmi_req, finish_ok, timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_sync <= '0;
            tms_sync <= '0;
            tdi_sync <= '0;
            tck_q    <= 1'b0;
        end else begin
            tck_sync <= {tck_sync[SYNC_STAGES-2:0], tck};
            tms_sync <= {tms_sync[SYNC_STAGES-2:0], tms};
            tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], tdi};
            tck_q    <= tck_sync[SYNC_STAGES-1];
        end
    end

    assign tck_s    = tck_sync[SYNC_STAGES-1];
    assign tms_s    = tms_sync[SYNC_STAGES-1];
    assign tdi_s    = tdi_sync[SYNC_STAGES-1];
    assign tck_rise = tck_s & ~tck_q;
    assign tck_fall = ~tck_s & tck_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tap_state <= TLR;
        else        tap_state <= tap_next;
    end

    always_comb begin
        tap_next = tap_state;
        if (tck_rise) begin
            unique case (tap_state)
                TLR:      tap_next = tms_s ? TLR      : RTI;
                RTI:      tap_next = tms_s ? SEL_DR   : RTI;
                SEL_DR:   tap_next = tms_s ? SEL_IR   : CAP_DR;
                CAP_DR:   tap_next = tms_s ? EXIT1_DR : SHIFT_DR;
                SHIFT_DR: tap_next = tms_s ? EXIT1_DR : SHIFT_DR;
                EXIT1_DR: tap_next = tms_s ? UPD_DR   : PAUSE_DR;
                PAUSE_DR: tap_next = tms_s ? EXIT2_DR : PAUSE_DR;
                EXIT2_DR: tap_next = tms_s ? UPD_DR   : SHIFT_DR;
                UPD_DR:   tap_next = tms_s ? SEL_DR   : RTI;
                SEL_IR:   tap_next = tms_s ? TLR      : CAP_IR;
                CAP_IR:   tap_next = tms_s ? EXIT1_IR : SHIFT_IR;
                SHIFT_IR: tap_next = tms_s ? EXIT1_IR : SHIFT_IR;
                EXIT1_IR: tap_next = tms_s ? UPD_IR   : PAUSE_IR;
                PAUSE_IR: tap_next = tms_s ? EXIT2_IR : PAUSE_IR;
                EXIT2_IR: tap_next = tms_s ? UPD_IR   : SHIFT_IR;
                UPD_IR:   tap_next = tms_s ? SEL_DR   : RTI;
                default:  tap_next = TLR;
            endcase
        end
    end

    assign tdo_en     = (tap_state == SHIFT_IR) || (tap_state == SHIFT_DR);
    assign sel_idcode = (ir == 5'h01);
    assign sel_dtmcs  = (ir == 5'h10);
    assign sel_dmi    = (ir == 5'h11);
    assign dmi_busy   = (dmi_state != D_IDLE);

    // TAP actions fire on the tck rise that leaves the Capture/Update states.
    assign upd_dtmcs   = tck_rise && (tap_state == UPD_DR) && sel_dtmcs;
    assign upd_dmi     = tck_rise && (tap_state == UPD_DR) && sel_dmi;
    assign cap_dmi     = tck_rise && (tap_state == CAP_DR) && sel_dmi;
    assign hard_reset  = upd_dtmcs && dr_shift[17];
    assign stat_clear  = upd_dtmcs && (dr_shift[16] || dr_shift[17]);
    assign busy_hit    = (upd_dmi || cap_dmi) && dmi_busy;
    assign dmi_req     = upd_dmi && !dmi_busy && (dmistat == 2'd0) &&
                         ((dr_shift[1:0] == 2'd1) || (dr_shift[1:0] == 2'd2));
    assign finish_ok   = dmi_finish && (dmi_state == D_WAIT) && !hard_reset;

    always_comb begin
        dr_capture = '0;
        if (sel_idcode)
            dr_capture[31:0] = IDCODE;
        else if (sel_dtmcs)
            dr_capture[31:0] = {14'd0, 3'b000, 3'd1, dmistat, 6'(ABITS), 4'd1};
        else if (sel_dmi)
            dr_capture = {dmi_address, rdata_buf, (dmi_busy ? 2'd3 : dmistat)};
    end

    always_comb begin
        dr_shifted = {{(DMI_W-1){1'b0}}, tdi_s};
        if (sel_idcode || sel_dtmcs)
            dr_shifted = {{(DMI_W-32){1'b0}}, tdi_s, dr_shift[31:1]};
        else if (sel_dmi)
            dr_shifted = {tdi_s, dr_shift[DMI_W-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir       <= 5'h01;
            ir_shift <= '0;
            dr_shift <= '0;
            tdo      <= 1'b0;
        end else begin
            if (tap_state == TLR) ir <= 5'h01;
            if (tck_rise) begin
                case (tap_state)
                    CAP_IR:   ir_shift <= 5'b00001;
                    SHIFT_IR: ir_shift <= {tdi_s, ir_shift[4:1]};
                    UPD_IR:   ir       <= ir_shift;
                    CAP_DR:   dr_shift <= dr_capture;
                    SHIFT_DR: dr_shift <= dr_shifted;
                    default:  ;
                endcase
            end
            if (tck_fall) begin
                if (tap_state == SHIFT_IR)      tdo <= ir_shift[0];
                else if (tap_state == SHIFT_DR) tdo <= dr_shift[0];
                else                            tdo <= 1'b0;
            end
        end
    end

    // dmistat clears win over the sticky busy flag, which wins over a watchdog expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmistat     <= 2'd0;
            rdata_buf   <= '0;
            dmi_op      <= 2'd0;
            dmi_address <= '0;
            dmi_wdata   <= '0;
        end else begin
            if (stat_clear)       dmistat <= 2'd0;
            else if (busy_hit)    dmistat <= 2'd3;
            else if (timeout_hit) dmistat <= 2'd2;
            if (finish_ok && (dmi_op == 2'd1)) rdata_buf <= dmi_rdata;
            if (dmi_req) begin
                dmi_address <= dr_shift[DMI_W-1:34];
                dmi_wdata   <= dr_shift[33:2];
                dmi_op      <= dr_shift[1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dmi_state <= D_IDLE;
        else        dmi_state <= dmi_next;
    end

    always_comb begin
        dmi_next = dmi_state;
        if (hard_reset) begin
            dmi_next = D_IDLE;
        end else begin
            unique case (dmi_state)
                D_IDLE:  if (dmi_req) dmi_next = D_REQ;
                D_REQ:   dmi_next = D_WAIT;
                D_WAIT:  if (finish_ok || timeout_hit) dmi_next = D_IDLE;
                default: dmi_next = D_IDLE;
            endcase
        end
    end

    assign dmi_start = (dmi_state == D_REQ);

`ifdef DTM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] wd_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   wd_cnt <= '0;
        else if (dmi_state == D_REQ)  wd_cnt <= '0;
        else if (dmi_state == D_WAIT) wd_cnt <= wd_cnt + CW'(1);
    end

    assign timeout_hit = (dmi_state == D_WAIT) && !dmi_finish && !hard_reset &&
                         (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

endmodule
